// File: rtl/seq_pkg.sv
// Shared constants, defaults and helpers for the MiniRISC program-flow sequencer.
package seq_pkg;

   localparam int DEF_ADDR_WIDTH      = 8;
   localparam int DEF_FLAG_WIDTH      = 6;
   localparam int DEF_STACK_DEPTH     = 16;
   localparam int DEF_IRQ_CHANNELS    = 4;
   localparam int DEF_RST_VECTOR      = 0;
   localparam int DEF_INT_VECTOR_BASE = 1;

   // Bit positions of the status flags saved alongside each return address.
   localparam int FLAG_Z  = 0;
   localparam int FLAG_C  = 1;
   localparam int FLAG_N  = 2;
   localparam int FLAG_V  = 3;
   localparam int FLAG_IE = 4;
   localparam int FLAG_IF = 5;

   typedef enum logic [2:0] {
      PC_SRC_INIT,
      PC_SRC_INT,
      PC_SRC_DBG,
      PC_SRC_JUMP,
      PC_SRC_RET,
      PC_SRC_FETCH,
      PC_SRC_HOLD
   } pc_src_e;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Controller-side bus of the program sequencer: execute strobes, debug access and stack status.
interface prog_sequencer_if import seq_pkg::*; #(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int FLAG_WIDTH   = DEF_FLAG_WIDTH,
   parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
   parameter int IRQ_CHANNELS = DEF_IRQ_CHANNELS
);
   localparam int CH_W  = clog2_min1(IRQ_CHANNELS);
   localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

   logic                         initialize;
   logic                         fetch;
   logic                         ex_jump;
   logic                         ex_call;
   logic                         ex_ret_sub;
   logic                         ex_ret_int;
   logic                         int_take;
   logic [IRQ_CHANNELS-1:0]      irq;
   logic [ADDR_WIDTH-1:0]        jump_addr;
   logic [FLAG_WIDTH-1:0]        flags_in;
   logic                         dbg_is_brk;
   logic                         dbg_pc_wr;
   logic                         dbg_clr_err;
   logic [ADDR_WIDTH-1:0]        dbg_data_in;

   logic [ADDR_WIDTH-1:0]        prg_mem_addr;
   logic                         int_pending;
   logic [CH_W-1:0]              int_channel;
   logic [FLAG_WIDTH-1:0]        flags_restore;
   logic                         flags_restore_wr;
   logic [ADDR_WIDTH+FLAG_WIDTH-1:0] stack_top;
   logic [LVL_W-1:0]             stack_level;
   logic                         stack_empty;
   logic                         stack_full;
   logic                         stack_ovf;
   logic                         stack_unf;

   modport master (
      output initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, int_take, irq,
             jump_addr, flags_in, dbg_is_brk, dbg_pc_wr, dbg_clr_err, dbg_data_in,
      input  prg_mem_addr, int_pending, int_channel, flags_restore, flags_restore_wr,
             stack_top, stack_level, stack_empty, stack_full, stack_ovf, stack_unf
   );

   modport slave (
      input  initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, int_take, irq,
             jump_addr, flags_in, dbg_is_brk, dbg_pc_wr, dbg_clr_err, dbg_data_in,
      output prg_mem_addr, int_pending, int_channel, flags_restore, flags_restore_wr,
             stack_top, stack_level, stack_empty, stack_full, stack_ovf, stack_unf
   );

endinterface

// File: rtl/lifo_stack.sv
// Return stack: register array with level counter, full/empty, and push+pop replace of the top.
module lifo_stack #(
   parameter int DATA_WIDTH = 14,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_WIDTH-1:0]   push_data,
   output logic [DATA_WIDTH-1:0]   top_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    empty,
   output logic                    full,
   output logic                    ovf_evt,
   output logic                    unf_evt
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int LVL_W = IDX_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [LVL_W-1:0]      level_q;
   logic [IDX_W-1:0]      top_idx;
   logic [IDX_W-1:0]      wr_idx;
   logic                  replace;
   logic                  wr_en;
   logic                  inc;
   logic                  dec;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign top_idx = level_q[IDX_W-1:0] - IDX_W'(1);

   // Push into an empty stack together with a pop degenerates to a plain push.
   assign replace = push & pop & ~empty;
   assign wr_en   = push & (pop | ~full);
   assign wr_idx  = replace ? top_idx : level_q[IDX_W-1:0];
   assign inc     = push & ~full & (~pop | empty);
   assign dec     = pop & ~push & ~empty;
   assign ovf_evt = push & ~pop & full;
   assign unf_evt = pop & ~push & empty;

   assign top_data = empty ? '0 : mem[top_idx];
   assign level    = level_q;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         level_q <= '0;
      else if (inc)
         level_q <= level_q + LVL_W'(1);
      else if (dec)
         level_q <= level_q - LVL_W'(1);
   end

endmodule

// File: rtl/prog_sequencer.sv
// MiniRISC program-flow sequencer: PC arbitration, vectored interrupts and a flag-saving return stack.
module prog_sequencer import seq_pkg::*; #(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int FLAG_WIDTH      = DEF_FLAG_WIDTH,
   parameter int STACK_DEPTH     = DEF_STACK_DEPTH,
   parameter int IRQ_CHANNELS    = DEF_IRQ_CHANNELS,
   parameter int RST_VECTOR      = DEF_RST_VECTOR,
   parameter int INT_VECTOR_BASE = DEF_INT_VECTOR_BASE
) (
   input  logic            clk,
   input  logic            rst,
   prog_sequencer_if.slave bus
);
   localparam int CH_W  = clog2_min1(IRQ_CHANNELS);
   localparam int LVL_W = $clog2(STACK_DEPTH) + 1;
   localparam int DW    = ADDR_WIDTH + FLAG_WIDTH;

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] int_vector;
   logic [CH_W-1:0]       irq_sel;
   logic [CH_W-1:0]       int_channel_q;
   logic                  push;
   logic                  pop;
   logic                  ovf_evt;
   logic                  unf_evt;
   logic                  ovf_q;
   logic                  unf_q;
   logic                  empty;
   logic                  full;
   logic [LVL_W-1:0]      level;
   logic [DW-1:0]         top_data;
   pc_src_e               pc_src;

   assign push = (bus.int_take | bus.ex_call) & ~bus.initialize;
   assign pop  = (bus.ex_ret_sub | bus.ex_ret_int) & ~bus.initialize;

   lifo_stack #(
      .DATA_WIDTH (DW),
      .DEPTH      (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data ({bus.flags_in, pc_q}),
      .top_data  (top_data),
      .level     (level),
      .empty     (empty),
      .full      (full),
      .ovf_evt   (ovf_evt),
      .unf_evt   (unf_evt)
   );

   // Lowest-index request wins; no request selects channel 0.
   always_comb begin
      irq_sel = '0;
      for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
         if (bus.irq[i])
            irq_sel = CH_W'(i);
      end
   end

   assign int_vector = ADDR_WIDTH'(INT_VECTOR_BASE) + ADDR_WIDTH'(irq_sel);

   always_comb begin
      if (bus.initialize)
         pc_src = PC_SRC_INIT;
      else if (bus.int_take)
         pc_src = PC_SRC_INT;
      else if (bus.dbg_is_brk & bus.dbg_pc_wr)
         pc_src = PC_SRC_DBG;
      else if (bus.ex_jump | bus.ex_call)
         pc_src = PC_SRC_JUMP;
      else if (bus.ex_ret_sub | bus.ex_ret_int)
         pc_src = PC_SRC_RET;
      else if (bus.fetch)
         pc_src = PC_SRC_FETCH;
      else
         pc_src = PC_SRC_HOLD;
   end

   always_comb begin
      pc_next = pc_q;
      case (pc_src)
         PC_SRC_INIT:  pc_next = ADDR_WIDTH'(RST_VECTOR);
         PC_SRC_INT:   pc_next = int_vector;
         PC_SRC_DBG:   pc_next = bus.dbg_data_in;
         PC_SRC_JUMP:  pc_next = bus.jump_addr;
         PC_SRC_RET:   pc_next = top_data[ADDR_WIDTH-1:0];
         PC_SRC_FETCH: pc_next = pc_q + ADDR_WIDTH'(1);
         default:      pc_next = pc_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= ADDR_WIDTH'(RST_VECTOR);
         int_channel_q <= '0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         pc_q <= pc_next;
         if (bus.int_take & ~bus.initialize)
            int_channel_q <= irq_sel;
         // Clearing beats a same-cycle error so software sees a clean slate.
         if (bus.initialize | bus.dbg_clr_err) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (ovf_evt)
               ovf_q <= 1'b1;
            if (unf_evt)
               unf_q <= 1'b1;
         end
      end
   end

   assign bus.prg_mem_addr     = pc_q;
   assign bus.int_pending      = |bus.irq;
   assign bus.int_channel      = int_channel_q;
   assign bus.stack_top        = top_data;
   assign bus.flags_restore    = top_data[DW-1:ADDR_WIDTH];
   assign bus.flags_restore_wr = bus.ex_ret_int & ~empty;
   assign bus.stack_level      = level;
   assign bus.stack_empty      = empty;
   assign bus.stack_full       = full;
   assign bus.stack_ovf        = ovf_q;
   assign bus.stack_unf        = unf_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized traffic against a queue model.
module tb_prog_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   prog_sequencer_if #(
      .ADDR_WIDTH(8), .FLAG_WIDTH(6), .STACK_DEPTH(16), .IRQ_CHANNELS(4)
   ) bus ();

   prog_sequencer #(
      .ADDR_WIDTH(8), .FLAG_WIDTH(6), .STACK_DEPTH(16), .IRQ_CHANNELS(4),
      .RST_VECTOR(0), .INT_VECTOR_BASE(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference state: PC, latched channel, sticky errors and the stack as a queue.
   logic [7:0]  m_pc;
   logic [1:0]  m_ch;
   logic        m_ovf;
   logic        m_unf;
   logic [13:0] m_stk[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [13:0] m_top();
      return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 14'h0;
   endfunction

   function automatic int lowest_irq(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pc = 8'h00; m_ch = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete();
   endtask

   task automatic check_model();
      logic [13:0] t;
      t = m_top();
      chk("prg_mem_addr", bus.prg_mem_addr, m_pc);
      chk("int_pending", bus.int_pending, |bus.irq);
      chk("int_channel", bus.int_channel, m_ch);
      chk("stack_top", bus.stack_top, t);
      chk("flags_restore", bus.flags_restore, t[13:8]);
      chk("flags_restore_wr", bus.flags_restore_wr, bus.ex_ret_int && m_stk.size() != 0);
      chk("stack_level", bus.stack_level, m_stk.size());
      chk("stack_empty", bus.stack_empty, m_stk.size() == 0);
      chk("stack_full", bus.stack_full, m_stk.size() == 16);
      chk("stack_ovf", bus.stack_ovf, m_ovf);
      chk("stack_unf", bus.stack_unf, m_unf);
   endtask

   task automatic model_step();
      logic        push, pop, set_ovf, set_unf;
      logic [13:0] pd, t;
      logic [7:0]  npc;
      int          ch;
      push = (bus.int_take || bus.ex_call) && !bus.initialize;
      pop  = (bus.ex_ret_sub || bus.ex_ret_int) && !bus.initialize;
      ch   = lowest_irq(bus.irq);
      t    = m_top();
      if (bus.initialize)                      npc = 8'h00;
      else if (bus.int_take)                   npc = 8'((1 + ch) % 256);
      else if (bus.dbg_is_brk && bus.dbg_pc_wr) npc = bus.dbg_data_in;
      else if (bus.ex_jump || bus.ex_call)     npc = bus.jump_addr;
      else if (bus.ex_ret_sub || bus.ex_ret_int) npc = t[7:0];
      else if (bus.fetch)                      npc = 8'((m_pc + 1) % 256);
      else                                     npc = m_pc;
      pd = {bus.flags_in, m_pc};
      set_ovf = 1'b0; set_unf = 1'b0;
      if (push && pop) begin
         if (m_stk.size() == 0) m_stk.push_back(pd);
         else m_stk[m_stk.size()-1] = pd;
      end else if (push) begin
         if (m_stk.size() == 16) set_ovf = 1'b1;
         else m_stk.push_back(pd);
      end else if (pop) begin
         if (m_stk.size() == 0) set_unf = 1'b1;
         else void'(m_stk.pop_back());
      end
      if (bus.initialize || bus.dbg_clr_err) begin
         m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         m_ovf = m_ovf | set_ovf;
         m_unf = m_unf | set_unf;
      end
      if (bus.int_take && !bus.initialize) m_ch = 2'(ch);
      m_pc = npc;
   endtask

   // Called just after a falling edge with inputs set; returns after the next falling edge.
   task automatic tick();
      #1;
      check_model();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.initialize = 0; bus.fetch = 0; bus.ex_jump = 0; bus.ex_call = 0;
      bus.ex_ret_sub = 0; bus.ex_ret_int = 0; bus.int_take = 0; bus.irq = '0;
      bus.jump_addr = '0; bus.flags_in = '0; bus.dbg_is_brk = 0; bus.dbg_pc_wr = 0;
      bus.dbg_clr_err = 0; bus.dbg_data_in = '0;
   endtask

   task automatic check_reset_values();
      chk("rst_pc", bus.prg_mem_addr, 8'h00);
      chk("rst_level", bus.stack_level, 0);
      chk("rst_empty", bus.stack_empty, 1);
      chk("rst_full", bus.stack_full, 0);
      chk("rst_ovf", bus.stack_ovf, 0);
      chk("rst_unf", bus.stack_unf, 0);
      chk("rst_channel", bus.int_channel, 0);
      chk("rst_top", bus.stack_top, 14'h0);
      chk("rst_flags_restore", bus.flags_restore, 6'h0);
   endtask

   task automatic rand_inputs(input int push_bias, input int pop_bias);
      bus.fetch       = ($urandom_range(0, 1) == 1);
      bus.irq         = 4'($urandom());
      bus.int_take    = ($urandom_range(0, 99) < 6 + push_bias);
      bus.ex_call     = ($urandom_range(0, 99) < 8 + push_bias);
      bus.ex_jump     = ($urandom_range(0, 99) < 8);
      bus.ex_ret_sub  = ($urandom_range(0, 99) < 8 + pop_bias);
      bus.ex_ret_int  = ($urandom_range(0, 99) < 6 + pop_bias);
      bus.initialize  = ($urandom_range(0, 99) < 2);
      bus.dbg_is_brk  = ($urandom_range(0, 99) < 10);
      bus.dbg_pc_wr   = ($urandom_range(0, 99) < 50);
      bus.dbg_clr_err = ($urandom_range(0, 99) < 4);
      bus.jump_addr   = 8'($urandom());
      bus.flags_in    = 6'($urandom());
      bus.dbg_data_in = 8'($urandom());
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_values();
      rst = 1'b0;

      // Sequential fetch from the reset vector.
      bus.fetch = 1;
      tick(); chk("fetch1", bus.prg_mem_addr, 8'h01);
      tick(); chk("fetch2", bus.prg_mem_addr, 8'h02);
      tick(); chk("fetch3", bus.prg_mem_addr, 8'h03);
      chk("fetch_empty", bus.stack_empty, 1);
      tick(); tick();
      chk("pc_at_5", bus.prg_mem_addr, 8'h05);

      // Call and return.
      idle(); bus.ex_call = 1; bus.jump_addr = 8'h40; bus.flags_in = 6'h03;
      tick();
      chk("call_pc", bus.prg_mem_addr, 8'h40);
      chk("call_top", bus.stack_top, 14'h0305);
      idle(); bus.ex_ret_sub = 1;
      tick();
      chk("ret_pc", bus.prg_mem_addr, 8'h05);
      chk("ret_level", bus.stack_level, 0);

      // Vectored interrupt entry and return.
      idle(); bus.dbg_is_brk = 1; bus.dbg_pc_wr = 1; bus.dbg_data_in = 8'h10;
      tick();
      idle(); bus.irq = 4'b1010; bus.int_take = 1; bus.flags_in = 6'h2A;
      tick();
      chk("int_pc", bus.prg_mem_addr, 8'h02);
      chk("int_channel", bus.int_channel, 1);
      chk("int_flags_saved", bus.flags_restore, 6'h2A);
      idle(); bus.ex_ret_int = 1;
      #1 chk("restore_wr_hi", bus.flags_restore_wr, 1);
      tick();
      chk("reti_pc", bus.prg_mem_addr, 8'h10);
      idle();
      #1 chk("restore_wr_lo", bus.flags_restore_wr, 0);

      // Overflow on the 17th call, then debug clear.
      idle(); bus.ex_call = 1; bus.jump_addr = 8'h20;
      for (int i = 0; i < 16; i++) tick();
      chk("full_level", bus.stack_level, 16);
      chk("full_flag", bus.stack_full, 1);
      chk("no_ovf_yet", bus.stack_ovf, 0);
      tick();
      chk("ovf_level", bus.stack_level, 16);
      chk("ovf_set", bus.stack_ovf, 1);
      idle(); bus.dbg_clr_err = 1;
      tick();
      chk("ovf_cleared", bus.stack_ovf, 0);

      // Drain, then underflow.
      idle(); bus.ex_ret_sub = 1;
      for (int i = 0; i < 16; i++) tick();
      tick();
      chk("unf_pc", bus.prg_mem_addr, 8'h00);
      chk("unf_set", bus.stack_unf, 1);
      chk("unf_level", bus.stack_level, 0);

      // Same-cycle interrupt entry and return replaces the top.
      idle(); bus.ex_call = 1; bus.jump_addr = 8'h30; tick();
      bus.jump_addr = 8'h31; tick();
      idle(); bus.irq = 4'b0100; bus.int_take = 1; bus.ex_ret_sub = 1; bus.flags_in = 6'h15;
      tick();
      chk("replace_level", bus.stack_level, 2);
      chk("replace_top", bus.stack_top, 14'h1531);
      chk("replace_pc", bus.prg_mem_addr, 8'h03);

      // Debug PC write outranks a jump.
      idle(); bus.dbg_is_brk = 1; bus.dbg_pc_wr = 1; bus.dbg_data_in = 8'h7F;
      bus.ex_jump = 1; bus.jump_addr = 8'h55;
      tick();
      chk("dbg_pc", bus.prg_mem_addr, 8'h7F);

      // Interrupt taken with no request uses the base vector.
      idle(); bus.int_take = 1;
      tick();
      chk("int_noirq_pc", bus.prg_mem_addr, 8'h01);
      chk("int_noirq_ch", bus.int_channel, 0);

      // Asynchronous reset between edges.
      idle(); bus.fetch = 1; tick(); tick();
      #3 rst = 1'b1;
      #1 check_reset_values();
      model_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Randomized traffic, alternating push-heavy and pop-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         if ((i / 150) % 2 == 0) rand_inputs(20, 0);
         else rand_inputs(0, 20);
         tick();
      end
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program-flow sequencer for the next-generation MiniRISC control unit. It holds the program counter and a configurable-depth return stack. It arbitrates among reset, interrupt entry, debug PC writes, jumps, calls, returns and sequential fetch, and adds vectored multi-channel interrupts plus stack overflow/underflow detection. It sits between the controller FSM, which supplies the one-cycle execute strobes, and the program memory address bus.

## Interface
- ADDR_WIDTH, 8: program address / PC width.
- FLAG_WIDTH, 6: status bits saved with each return address (Z,C,N,V,IE,IF order, LSB first).
- STACK_DEPTH, 16: return stack entries, power of two, ≥2.
- IRQ_CHANNELS, 4: interrupt request lines, 1..16.
- RST_VECTOR, 0: PC value after reset/initialize.
- INT_VECTOR_BASE, 1: vector of channel 0; channel k vectors to INT_VECTOR_BASE+k (mod 2^ADDR_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- initialize  in  1  synchronous re-init from FSM.
- fetch  in  1  advance PC by 1.
- ex_jump, ex_call  in  1 each  load jump_addr; ex_call also pushes.
- ex_ret_sub, ex_ret_int  in  1 each  pop and load return address.
- int_take  in  1  FSM accepts interrupt this cycle.
- irq  in  IRQ_CHANNELS  level-sensitive requests, active-high.
- jump_addr  in  ADDR_WIDTH  jump/call target.
- flags_in  in  FLAG_WIDTH  live flags to save on push.
- dbg_is_brk, dbg_pc_wr, dbg_clr_err  in  1 each  debug control.
- dbg_data_in  in  ADDR_WIDTH  debug PC value.
- prg_mem_addr  out  ADDR_WIDTH  current PC.
- int_pending  out  1  OR of irq.
- int_channel  out  $clog2(IRQ_CHANNELS) (min 1)  channel latched at last int_take.
- flags_restore  out  FLAG_WIDTH  flag field of stack top.
- flags_restore_wr  out  1  ex_ret_int & ~stack_empty.
- stack_top  out  ADDR_WIDTH+FLAG_WIDTH  {flags,pc} at top; 0 when empty.
- stack_level  out  $clog2(STACK_DEPTH)+1  entry count.
- stack_empty, stack_full  out  1 each.
- stack_ovf, stack_unf  out  1 each  sticky error flags.

## Operation
- PC priority, highest first: initialize → int_take → (dbg_is_brk & dbg_pc_wr) → ex_jump|ex_call → ex_ret_sub|ex_ret_int → fetch → hold.
- int_take: selected channel = lowest-index asserted irq bit; PC ← INT_VECTOR_BASE+ch; int_channel ← ch. If int_take with irq==0: PC ← INT_VECTOR_BASE, int_channel ← 0.
- Push = int_take | ex_call; data {flags_in, PC before update}. Pop = ex_ret_sub | ex_ret_int; PC ← stack_top[ADDR_WIDTH-1:0].
- Push while full: entry discarded, level stays STACK_DEPTH, stack_ovf ← 1; PC still loads target.
- Pop while empty: level stays 0, stack_unf ← 1; PC ← 0 (stack_top is 0).
- Push and pop in the same cycle: top entry overwritten with push data, level unchanged; if empty, acts as plain push.
- Stack ops are suppressed on cycles where initialize is high.
- stack_ovf/stack_unf cleared by rst, initialize, or dbg_clr_err (clear wins over set in the same cycle).
- Stack contents are not cleared by reset; only level resets.

## Timing
- All state changes at the rising clk edge following the strobe; prg_mem_addr is the registered PC (1-cycle latency).
- stack_top, flags_restore, flags_restore_wr, stack_empty/full and int_pending are combinational from registered state/inputs.
- Reset values: PC=RST_VECTOR, stack_level=0, stack_empty=1, stack_full=0, stack_ovf=stack_unf=0, int_channel=0, stack_top=0, flags_restore=0.
- rst asserted mid-operation aborts any push/pop immediately; no partial entry is visible after release.
- PC wraps modulo 2^ADDR_WIDTH on fetch and on vector addition.

## Structure
- Shared package seq_pkg: default widths, vector constants, the flag bit-index constants, and function clog2_min1.
- One sub-module, lifo_stack (DATA_WIDTH, DEPTH): register-array storage, level counter, full/empty, and same-cycle replace. The sequencer owns the PC, arbitration, priority encoder and error flags.

## Test plan
- Reset then 3 fetches → prg_mem_addr 0,1,2,3; stack_empty=1.
- ex_call with jump_addr=0x40 at PC=0x05, flags_in=6'h03 → PC=0x40, stack_top={6'h03,8'h05}. Then ex_ret_sub → PC=0x05, level 0.
- irq=4'b1010, int_take at PC=0x10 → PC=0x02, int_channel=1. Then ex_ret_int → PC=0x10, flags_restore_wr=1 for one cycle.
- 17 calls with STACK_DEPTH=16 → level 16, stack_ovf=1 after the 17th. dbg_clr_err → stack_ovf=0.
- ex_ret_sub on empty stack → PC=0x00, stack_unf=1, level 0. Same-cycle int_take+ex_ret_sub at level 2 → top replaced, level 2, PC=vector.
- dbg_is_brk & dbg_pc_wr with dbg_data_in=0x7F together with ex_jump → PC=0x7F. rst pulse mid-sequence → all outputs at reset values.
